raster_scheduler: RTL and testbench

//  Shares one rasterizer between NREQ triangle producers. Round-robin arbitration picks a

---
 rtl/raster_pkg.sv | 18 +
 rtl/raster_scheduler_arb.sv | 37 +++
 rtl/raster_scheduler.sv | 138 +++++++++++++
 tb/tb_raster_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types and constants for the raster scheduler slice.
// Triangle word is nine 16-bit Q10.6 fields {x1,y1,c1,x2,y2,c2,x3,y3,c3}, x1 in the MSBs.
// Scheduler FSM state encoding lives here so the top and any debug logic agree on it.
package raster_pkg;

  localparam int FIELD_W = 16;
  localparam int FRAC    = 6;
  localparam int NFIELDS = 9;
  localparam int TRI_W   = FIELD_W * NFIELDS;

  // Scheduler states: IDLE=0, SHIFT=1, WAIT_DONE=2.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/raster_scheduler_arb.sv
// Round-robin arbiter: picks the first asserted request after the last grant, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter
  import raster_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            gnt_vld_o
);

  logic [IDW-1:0] cand;
  logic           found;

  // Scan from last_i+1 around the ring; the first valid requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
    gnt_vld_o = found;
  end

endmodule

// File: rtl/raster_scheduler.sv
// Shares one serial rasterizer among NREQ producers: arbitrate, latch, shift MSB-first, await DONE.
// Latency: START rises the cycle after the handshake, lasts TRI_W cycles, then waits for DONE/timeout.
// Backpressure: REQ_READY only asserts in IDLE, so producers stall while a triangle is in flight.
module raster_scheduler
  import raster_pkg::*;
#(
  parameter int          NREQ    = 2,
  parameter int          TRI_W   = raster_pkg::TRI_W,
  parameter int          TO_W    = 20,
  parameter int unsigned TIMEOUT = 32'h000F_FFFF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          REQ_VALID,
  input  logic [NREQ*TRI_W-1:0]    REQ_DATA,
  output logic [NREQ-1:0]          REQ_READY,
  output logic                     RAST_D,
  output logic                     RAST_START,
  input  logic                     RAST_DONE,
  output logic [$clog2(NREQ)-1:0]  GRANT_ID,
  output logic                     BUSY,
  output logic                     TRI_DONE,
  output logic                     TIMEOUT_ERR
);

  localparam int             IDW     = $clog2(NREQ);
  localparam int             BCW     = $clog2(TRI_W);
  localparam logic [BCW-1:0] BC_LAST = BCW'(TRI_W - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [TRI_W-1:0]    shreg_q, shreg_d;
  logic [BCW-1:0]      bitcnt_q, bitcnt_d;
  logic [TO_W-1:0]     tocnt_q, tocnt_d;
  logic [IDW-1:0]      rr_last_q, rr_last_d;
  logic [IDW-1:0]      gid_q, gid_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                tri_done_q, tri_done_d;
  logic                to_err_q, to_err_d;

  logic [NREQ-1:0]     arb_gnt;
  logic [IDW-1:0]      arb_idx;
  logic                arb_vld;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i     (REQ_VALID),
    .last_i    (rr_last_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  // Next-state and handshake logic; READY is suppressed while RST is held so no word is lost.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    tocnt_d    = tocnt_q;
    rr_last_d  = rr_last_q;
    gid_d      = gid_q;
    tri_done_d = 1'b0;
    to_err_d   = 1'b0;
    REQ_READY  = '0;
    case (state_q)
      IDLE: begin
        if (!RST && arb_vld) begin
          REQ_READY = arb_gnt;
          shreg_d   = REQ_DATA[arb_idx*TRI_W +: TRI_W];
          gid_d     = arb_idx;
          rr_last_d = arb_idx;
          bitcnt_d  = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Zeros shift in behind the word, so RAST_D reads 0 once the word is out.
        shreg_d  = {shreg_q[TRI_W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == BC_LAST) begin
          tocnt_d = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        tocnt_d = tocnt_q + 1'b1;
        if (RAST_DONE) begin
          tri_done_d = 1'b1;
          state_d    = IDLE;
        end else if (tocnt_q == TO_LAST) begin
          to_err_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d == SHIFT);
    busy_d  = (state_d != IDLE);
  end

  // State, datapath and registered outputs; reset returns arbitration to favour requester 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      tocnt_q    <= '0;
      rr_last_q  <= IDW'(NREQ - 1);
      gid_q      <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      tri_done_q <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      tocnt_q    <= tocnt_d;
      rr_last_q  <= rr_last_d;
      gid_q      <= gid_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      tri_done_q <= tri_done_d;
      to_err_q   <= to_err_d;
    end
  end

  assign RAST_D      = shreg_q[TRI_W-1];
  assign RAST_START  = start_q;
  assign BUSY        = busy_q;
  assign GRANT_ID    = gid_q;
  assign TRI_DONE    = tri_done_q;
  assign TIMEOUT_ERR = to_err_q;

endmodule

// File: tb/tb_raster_scheduler.sv
// Bench for raster_scheduler: directed scenarios plus a cycle model compared every cycle.
// Model tracks phase/bit index/wait count from the behavioural rules, not the RTL registers.
// Uses TIMEOUT=100 so the abort path is reachable in a short run.
module tb_raster_scheduler;

  localparam int NREQ = 2;
  localparam int TW   = 144;
  localparam int TOV  = 100;

  localparam logic [TW-1:0] W1  = 144'h0040_0040_F800_0100_0040_F800_0080_0100_0080;
  localparam logic [TW-1:0] W2A = 144'h1234_5678_9ABC_DEF0_0F0F_F0F0_AAAA_5555_C3C3;
  localparam logic [TW-1:0] W2B = 144'h8001_7FFE_0000_FFFF_1111_2222_3333_4444_5555;
  localparam logic [TW-1:0] W3  = 144'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF_FEDC;
  localparam logic [TW-1:0] W4  = 144'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000_FFFF;
  localparam logic [TW-1:0] W5  = 144'h0001_0002_0004_0008_0010_0020_0040_0080_0100;
  localparam logic [TW-1:0] W6  = 144'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_6969_9696_7E7E;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*TW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rast_d, rast_start, rast_done;
  logic [0:0]         grant_id;
  logic               busy, tri_done, to_err;

  always #5 clk = ~clk;

  raster_scheduler #(
    .NREQ    (NREQ),
    .TRI_W   (TW),
    .TO_W    (20),
    .TIMEOUT (TOV)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .REQ_VALID   (req_valid),
    .REQ_DATA    (req_data),
    .REQ_READY   (req_ready),
    .RAST_D      (rast_d),
    .RAST_START  (rast_start),
    .RAST_DONE   (rast_done),
    .GRANT_ID    (grant_id),
    .BUSY        (busy),
    .TRI_DONE    (tri_done),
    .TIMEOUT_ERR (to_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    int c;
    for (int k = 1; k <= NREQ; k++) begin
      c = (last + k) % NREQ;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  // ---------------- behavioural model ----------------
  int            m_phase = 0;   // 0 idle, 1 sending, 2 awaiting done
  int            m_k = 0, m_t = 0, m_last = NREQ - 1, m_gid = 0;
  logic [TW-1:0] m_word = '0;
  bit            m_td = 0, m_to = 0, m_live = 0;

  always @(posedge clk) begin
    m_td = 0;
    m_to = 0;
    if (rst) begin
      m_phase = 0; m_last = NREQ - 1; m_gid = 0; m_live = 1;
    end else begin
      case (m_phase)
        0: if (req_valid != 0) begin
          m_gid   = pick(req_valid, m_last);
          m_last  = m_gid;
          m_word  = req_data[m_gid*TW +: TW];
          m_phase = 1;
          m_k     = 0;
        end
        1: if (m_k == TW - 1) begin m_phase = 2; m_t = 0; end
           else m_k++;
        default: if (rast_done) begin m_td = 1; m_phase = 0; end
                 else if (m_t == TOV - 1) begin m_to = 1; m_phase = 0; end
                 else m_t++;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    if (m_live) begin
      er = '0;
      if (m_phase == 0 && !rst && req_valid != 0) er[pick(req_valid, m_last)] = 1'b1;
      chk_b("model_ready0", req_ready[0], er[0]);
      chk_b("model_ready1", req_ready[1], er[1]);
      chk_b("model_start", rast_start, m_phase == 1);
      chk_b("model_d", rast_d, (m_phase == 1) ? m_word[TW-1-m_k] : 1'b0);
      chk_b("model_busy", busy, m_phase != 0);
      chk_b("model_tri_done", tri_done, m_td);
      chk_b("model_timeout_err", to_err, m_to);
      chk_i("model_grant_id", int'(grant_id), m_gid);
    end
  end

  // ---------------- observation ----------------
  int            cyc = 0, cap_n = 0, n_td = 0, n_to = 0, last_start_cyc = 0, to_cyc = 0;
  int            rdy_cnt [NREQ];
  int            glog [$];
  logic [TW-1:0] cap_word = '0;

  initial for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;

  always @(negedge clk) begin
    cyc++;
    if (req_ready != 0) begin
      glog.push_back(req_ready[1] ? 1 : 0);
      rdy_cnt[req_ready[1] ? 1 : 0]++;
      cap_n = 0;
    end
    if (rast_start) begin
      cap_word = {cap_word[TW-2:0], rast_d};
      cap_n++;
      last_start_cyc = cyc;
    end
    if (tri_done) n_td++;
    if (to_err) begin n_to++; to_cyc = cyc; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rast_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send(input int r, input logic [TW-1:0] w);
    req_data[r*TW +: TW] = w;
    req_valid[r] = 1'b1;
    tick();
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_wait_entry(input string nm);
    int n = 0;
    while (!(busy && !rast_start) && n < 400) begin tick(); n++; end
    chk_b(nm, busy && !rast_start, 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 400) begin tick(); n++; end
    chk_b(nm, busy, 1'b0);
  endtask

  task automatic pulse_done_after(input int dly);
    repeat (dly) tick();
    rast_done = 1'b1;
    tick();
    rast_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int td0, to0, g0, r0, r1;
    rst = 1'b1; req_valid = '0; req_data = '0; rast_done = 1'b0;

    // Reset state
    do_reset();
    chk_b("rst_start", rast_start, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_d", rast_d, 1'b0);
    chk_i("rst_ready", int'(req_ready), 0);
    chk_b("rst_tri_done", tri_done, 1'b0);
    chk_b("rst_timeout_err", to_err, 1'b0);

    // 1: single triangle, DONE 50 cycles into the wait
    td0 = n_td;
    send(0, W1);
    chk_i("t1_grant_id", int'(grant_id), 0);
    wait_wait_entry("t1_reach_wait");
    pulse_done_after(50);
    wait_idle("t1_reach_idle");
    tick();
    chk_i("t1_start_cycles", cap_n, 144);
    chk("t1_deserialized", cap_word, W1);
    chk_i("t1_tri_done_count", n_td - td0, 1);

    // 2: both valid for four triangles -> 0,1,0,1
    do_reset();
    glog.delete();
    r0 = rdy_cnt[0]; r1 = rdy_cnt[1];
    req_data = {W2B, W2A};
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_wait_entry("t2_reach_wait");
      if (n == 3) req_valid = '0;
      pulse_done_after(3);
    end
    wait_idle("t2_reach_idle");
    tick();
    chk_i("t2_grant_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk_i("t2_grant_0", glog[0], 0);
      chk_i("t2_grant_1", glog[1], 1);
      chk_i("t2_grant_2", glog[2], 0);
      chk_i("t2_grant_3", glog[3], 1);
    end
    chk_i("t2_ready0_cycles", rdy_cnt[0] - r0, 2);
    chk_i("t2_ready1_cycles", rdy_cnt[1] - r1, 2);

    // 3: DONE during shift bit 70 is ignored
    do_reset();
    td0 = n_td;
    send(0, W3);
    repeat (70) tick();
    rast_done = 1'b1;
    tick();
    rast_done = 1'b0;
    wait_wait_entry("t3_reach_wait");
    chk_i("t3_no_early_tri_done", n_td - td0, 0);
    pulse_done_after(10);
    wait_idle("t3_reach_idle");
    tick();
    chk_i("t3_tri_done_count", n_td - td0, 1);

    // 4: timeout after 100 wait cycles, then a new request is accepted
    do_reset();
    td0 = n_td; to0 = n_to;
    send(1, W4);
    wait_wait_entry("t4_reach_wait");
    wait_idle("t4_reach_idle");
    tick();
    chk_i("t4_timeout_distance", to_cyc - last_start_cyc, 101);
    chk_i("t4_timeout_count", n_to - to0, 1);
    chk_i("t4_no_tri_done", n_td - td0, 0);
    g0 = glog.size();
    send(0, W1);
    chk_b("t4_next_busy", busy, 1'b1);
    chk_i("t4_next_accepted", glog.size(), g0 + 1);
    wait_wait_entry("t4b_reach_wait");
    pulse_done_after(2);
    wait_idle("t4b_reach_idle");
    tick();

    // 5: reset at shift bit 37, then rr restarts at requester 0
    do_reset();
    send(0, W5);
    repeat (37) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_b("t5_start_after_rst", rast_start, 1'b0);
    chk_b("t5_busy_after_rst", busy, 1'b0);
    chk_i("t5_ready_after_rst", int'(req_ready), 0);
    req_data = {W6, W5};
    req_valid = 2'b11;
    g0 = glog.size();
    tick();
    chk_i("t5_first_grant", glog[$], 0);
    req_valid[0] = 1'b0;
    wait_wait_entry("t5_reach_wait");
    pulse_done_after(4);
    tick();
    chk_b("t5_req1_busy", busy, 1'b1);
    chk_i("t5_grant_count", glog.size(), g0 + 2);
    chk_i("t5_second_grant", glog[$], 1);
    req_valid = '0;
    wait_wait_entry("t5b_reach_wait");
    pulse_done_after(4);
    wait_idle("t5_reach_idle");
    tick();

    // 6: valid only during handshake, data changes afterwards
    do_reset();
    send(0, W6);
    req_data = '1;
    wait_wait_entry("t6_reach_wait");
    chk_i("t6_start_cycles", cap_n, 144);
    chk("t6_deserialized", cap_word, W6);
    pulse_done_after(1);
    wait_idle("t6_reach_idle");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
